mul_vec_result_stage: RTL and testbench



---
 rtl/mul_vec_result_stage.sv | 113 +++++++++++
 tb/tb_mul_vec_result_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mul_vec_result_stage.sv
// Writeback stage behind the fixed-latency vector multiplier: tracks in-flight ops,
// narrows the double-width product per element and queues results behind a credit counter.
module mul_vec_result_stage #(
  parameter int MUL_LATENCY = 2,
  parameter int DEPTH       = 4,
  parameter int TAG_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [2:0]       issue_osize,
  input  logic             issue_high,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic [255:0]     mul_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [2:0]       out_osize
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [2:0]       osize;
    logic             high;
    logic [TAG_W-1:0] tag;
  } meta_t;

  logic [CW-1:0]          credits;
  logic                   fire, pop, push;
  logic [MUL_LATENCY-1:0] vld_pipe;
  meta_t                  meta_pipe [MUL_LATENCY];
  meta_t                  fin;
  logic [127:0]           narrowed;

  assign issue_ready = (credits != '0);
  assign fire        = issue_valid & issue_ready;
  assign pop         = out_valid & out_ready;
  assign push        = vld_pipe[MUL_LATENCY-1];
  assign fin         = meta_pipe[MUL_LATENCY-1];

  // A credit covers an op from issue until its result is popped, so the FIFO cannot overflow.
  always_ff @(posedge clk) begin
    if (rst)               credits <= CW'(DEPTH);
    else if (fire && !pop) credits <= credits - 1'b1;
    else if (pop && !fire) credits <= credits + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else begin
      vld_pipe[0] <= fire;
      for (int i = 1; i < MUL_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    meta_pipe[0] <= '{osize: issue_osize, high: issue_high, tag: issue_tag};
    for (int i = 1; i < MUL_LATENCY; i++) meta_pipe[i] <= meta_pipe[i-1];
  end

  // Element i of width S sits at [i*2S +: 2S]; high picks its upper S bits.
  always_comb begin
    narrowed = '0;
    case (fin.osize)
      3'd0: for (int i = 0; i < 16; i++) narrowed[i*8 +: 8]    = mul_result[i*16  + (fin.high ? 8  : 0) +: 8];
      3'd1: for (int i = 0; i < 8;  i++) narrowed[i*16 +: 16]  = mul_result[i*32  + (fin.high ? 16 : 0) +: 16];
      3'd2: for (int i = 0; i < 4;  i++) narrowed[i*32 +: 32]  = mul_result[i*64  + (fin.high ? 32 : 0) +: 32];
      3'd3: for (int i = 0; i < 2;  i++) narrowed[i*64 +: 64]  = mul_result[i*128 + (fin.high ? 64 : 0) +: 64];
      3'd4: narrowed = fin.high ? mul_result[255:128] : mul_result[127:0];
      default: narrowed = '0;
    endcase
  end

  logic [127:0]       fifo_data  [DEPTH];
  logic [TAG_W-1:0]   fifo_tag   [DEPTH];
  logic [2:0]         fifo_osize [DEPTH];
  logic [PW-1:0]      rd_ptr, wr_ptr;
  logic [CW-1:0]      count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr]  <= narrowed;
      fifo_tag[wr_ptr]   <= fin.tag;
      fifo_osize[wr_ptr] <= fin.osize;
    end
  end

  // Head is gated so stale storage never shows while empty.
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? fifo_data[rd_ptr]  : '0;
  assign out_tag   = out_valid ? fifo_tag[rd_ptr]   : '0;
  assign out_osize = out_valid ? fifo_osize[rd_ptr] : '0;
endmodule

// File: tb/tb_mul_vec_result_stage.sv
// Directed bench for mul_vec_result_stage: narrowing table plus credit/order/reset sequences.
module tb_mul_vec_result_stage;
  localparam int L = 2;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         issue_valid, issue_ready, issue_high;
  logic [2:0]   issue_osize;
  logic [4:0]   issue_tag;
  logic [255:0] mul_result;
  logic         out_valid, out_ready;
  logic [127:0] out_data;
  logic [4:0]   out_tag;
  logic [2:0]   out_osize;

  int n_chk = 0;
  int n_fail = 0;

  mul_vec_result_stage #(.MUL_LATENCY(L), .DEPTH(D), .TAG_W(5)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_osize(issue_osize),
    .issue_high(issue_high), .issue_tag(issue_tag), .mul_result(mul_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_osize(out_osize)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]   osize;
    logic         high;
    logic [255:0] res;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int acc;
    logic [127:0] hi, lo;
    hi = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
    lo = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;
    vecs[0]  = '{3'd0, 1'b0, 256'h01FE, 128'hFE};
    vecs[1]  = '{3'd0, 1'b1, 256'h01FE, 128'h01};
    vecs[2]  = '{3'd4, 1'b1, {hi, lo}, hi};
    vecs[3]  = '{3'd4, 1'b0, {hi, lo}, lo};
    vecs[4]  = '{3'd1, 1'b0, 256'h0000_1234_ABCD_5678, 128'h1234_5678};
    vecs[5]  = '{3'd1, 1'b1, 256'h0000_1234_ABCD_5678, 128'hABCD};
    vecs[6]  = '{3'd2, 1'b1, 256'hFEDCBA98_76543210_89ABCDEF_01234567, 128'hFEDCBA98_89ABCDEF};
    vecs[7]  = '{3'd3, 1'b0, {{4{16'hAAAA}}, {4{16'hBBBB}}, {4{16'hCCCC}}, {4{16'hDDDD}}},
                 {{4{16'hBBBB}}, {4{16'hDDDD}}}};
    vecs[8]  = '{3'd3, 1'b1, {{4{16'hAAAA}}, {4{16'hBBBB}}, {4{16'hCCCC}}, {4{16'hDDDD}}},
                 {{4{16'hAAAA}}, {4{16'hCCCC}}}};
    vecs[9]  = '{3'd5, 1'b0, {256{1'b1}}, 128'h0};
    vecs[10] = '{3'd0, 1'b1, {16{16'hA55A}}, {16{8'hA5}}};

    rst = 1'b1; issue_valid = 1'b0; issue_osize = '0; issue_high = 1'b0;
    issue_tag = '0; mul_result = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset out_valid", out_valid, 0);
    chk("reset issue_ready", issue_ready, 1);
    chk("reset out_data", out_data, 0);
    chk("reset out_tag", out_tag, 0);
    chk("reset out_osize", out_osize, 0);

    // Narrowing table: issue one op, drive its product L cycles later, check next cycle.
    out_ready = 1'b1;
    for (int v = 0; v < 11; v++) begin
      @(negedge clk);
      issue_valid = 1'b1; issue_osize = vecs[v].osize; issue_high = vecs[v].high;
      issue_tag = 5'(v + 1);
      repeat (L) begin
        @(negedge clk);
        issue_valid = 1'b0;
      end
      chk("not early", out_valid, 0);
      mul_result = vecs[v].res;
      @(negedge clk);
      mul_result = '0;
      chk($sformatf("vec%0d valid", v), out_valid, 1);
      chk($sformatf("vec%0d data", v), out_data, vecs[v].exp);
      chk($sformatf("vec%0d tag", v), out_tag, 5'(v + 1));
      chk($sformatf("vec%0d osize", v), out_osize, vecs[v].osize);
    end
    @(negedge clk);
    chk("drained", out_valid, 0);

    // Backpressure: exactly D accepts with out_ready low.
    out_ready = 1'b0; issue_valid = 1'b1; issue_osize = 3'd0; issue_high = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      issue_tag = 5'(20 + acc);
      if (issue_ready) acc++;
      @(negedge clk);
    end
    chk("bp accepts", acc, D);
    chk("bp ready low", issue_ready, 0);
    issue_valid = 1'b0;
    chk("bp head valid", out_valid, 1);
    chk("bp head tag", out_tag, 20);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("pop raises ready", issue_ready, 1);
    chk("after pop tag", out_tag, 21);

    // Issue and pop together at credits=1: credit count must stay at 1.
    issue_valid = 1'b1; issue_tag = 5'd24; out_ready = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0; out_ready = 1'b0;
    chk("simul ready", issue_ready, 1);
    chk("simul head tag", out_tag, 22);
    issue_valid = 1'b1; issue_tag = 5'd25; acc = 0;
    for (int c = 0; c < 6; c++) begin
      if (issue_ready) acc++;
      @(negedge clk);
    end
    issue_valid = 1'b0;
    chk("simul credits", acc, 1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d valid", k), out_valid, 1);
      chk($sformatf("drain%0d tag", k), out_tag, 22 + k);
      @(negedge clk);
    end
    chk("drain empty", out_valid, 0);

    // Ordering and throughput: 8 back-to-back issues with out_ready held high.
    for (int j = 0; j < 9 + L; j++) begin
      if (j < 8) chk($sformatf("thru ready%0d", j), issue_ready, 1);
      if (j >= L + 1 && j - (L + 1) < 8) begin
        chk($sformatf("thru valid%0d", j), out_valid, 1);
        chk($sformatf("thru tag%0d", j), out_tag, j - (L + 1));
      end
      issue_valid = (j < 8);
      issue_tag = 5'(j);
      @(negedge clk);
    end
    issue_valid = 1'b0;
    chk("thru empty", out_valid, 0);

    // Reset with one entry queued and two ops in flight.
    out_ready = 1'b0;
    issue_valid = 1'b1; issue_tag = 5'd10; @(negedge clk);
    issue_valid = 1'b0; @(negedge clk);
    issue_valid = 1'b1; issue_tag = 5'd11; @(negedge clk);
    issue_tag = 5'd12; @(negedge clk);
    chk("pre-rst queued", out_valid, 1);
    issue_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst out_valid", out_valid, 0);
    chk("rst issue_ready", issue_ready, 1);
    chk("rst out_tag", out_tag, 0);
    chk("rst out_data", out_data, 0);
    mul_result = {256{1'b1}}; out_ready = 1'b1; acc = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) acc++;
      @(negedge clk);
    end
    chk("discarded never out", acc, 0);
    out_ready = 1'b0; issue_valid = 1'b1; acc = 0;
    for (int c = 0; c < 8; c++) begin
      if (issue_ready) acc++;
      @(negedge clk);
    end
    issue_valid = 1'b0;
    chk("rst credits", acc, D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
